// File: rtl/regfile_pkg.sv
// Shared constants and the write-request record for the register-file write port.
package regfile_pkg;

   localparam int REG_COUNT = 32;
   localparam int ADDR_W    = 5;
   localparam int WORD_W    = 64;
   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/regfile_write_port_decoder5_32.sv
// Combinational 5-to-32 one-hot decoder with enable, built as a 2-to-4
// group select driving four 3-to-8 stages.
module decoder5_32
   import regfile_pkg::*;
(
   input  logic                 en,
   input  logic [ADDR_W-1:0]    addr,
   output logic [REG_COUNT-1:0] onehot
);

   logic [3:0] grp;

   always_comb begin
      grp = '0;
      if (en) grp[addr[4:3]] = 1'b1;
   end

   for (genvar g = 0; g < 4; g++) begin : g_dec3_8
      assign onehot[g*8 +: 8] = grp[g] ? (8'b0000_0001 << addr[2:0]) : 8'b0;
   end

endmodule

// File: rtl/regfile_write_port.sv
// Write-side controller for the 32 x 64 register file: buffered WB requests
// drained as a registered one-hot write enable. Optional RF_BYPASS_EN adds a read bypass lookup.
module regfile_write_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_regwrite,
   input  logic [ADDR_W-1:0]    in_addr,
   input  logic [DATA_W-1:0]    in_data,
   input  logic                 drain_stall,
   output logic [REG_COUNT-1:0] wr_en,
   output logic [DATA_W-1:0]    wr_data,
`ifdef RF_BYPASS_EN
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic                 byp_hit,
   output logic [DATA_W-1:0]    byp_data,
`endif
   output logic [1:0]           pending
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   // The FIFO record carries the package word width, so the two must agree.
   if (DATA_W != WORD_W) begin : g_width_check
      $error("regfile_write_port: DATA_W must equal regfile_pkg::WORD_W");
   end

   wr_req_t              fifo_q [DEPTH];
   wr_req_t              head;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 push;
   logic                 pop;
   logic [REG_COUNT-1:0] wr_en_p0;

   assign in_ready = (count < CNT_W'(DEPTH));
   assign pending  = count[1:0];

   // Zero-register and non-RegWrite requests are consumed without occupying a slot.
   assign push = in_valid && in_ready && in_regwrite && (in_addr != ZERO_REG);
   assign pop  = (count != '0) && !drain_stall;
   assign head = fifo_q[rd_ptr];

   decoder5_32 u_dec (
      .en     (pop),
      .addr   (head.addr),
      .onehot (wr_en_p0)
   );

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr] <= '{addr: in_addr, data: in_data};
   end

   // Stage p0 -> p1: pointers, occupancy and the registered write strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         wr_en   <= '0;
         wr_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         wr_en <= wr_en_p0;
         if (pop) wr_data <= head.data;
      end
   end

`ifdef RF_BYPASS_EN
   // Later FIFO entries overwrite earlier hits, so the newest match wins over the strobe register.
   always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      if (rd_addr != ZERO_REG) begin
         if (wr_en[rd_addr]) begin
            byp_hit  = 1'b1;
            byp_data = wr_data;
         end
         for (int i = 0; i < DEPTH; i++) begin
            automatic logic [PTR_W-1:0] idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (fifo_q[idx].addr == rd_addr)) begin
               byp_hit  = 1'b1;
               byp_data = fifo_q[idx].data;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port; covers RF_BYPASS_EN when that macro is defined.
module tb_regfile_write_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_regwrite;
   logic [4:0]  in_addr;
   logic [63:0] in_data;
   logic        drain_stall;
   logic [31:0] wr_en;
   logic [63:0] wr_data;
   logic [1:0]  pending;
`ifdef RF_BYPASS_EN
   logic [4:0]  rd_addr;
   logic        byp_hit;
   logic [63:0] byp_data;
`endif

   int checks = 0;
   int errors = 0;

   regfile_write_port #(.DATA_W(64), .DEPTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_regwrite (in_regwrite),
      .in_addr     (in_addr),
      .in_data     (in_data),
      .drain_stall (drain_stall),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
`ifdef RF_BYPASS_EN
      .rd_addr     (rd_addr),
      .byp_hit     (byp_hit),
      .byp_data    (byp_data),
`endif
      .pending     (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic rw, input logic [4:0] a, input logic [63:0] d);
      in_valid    = v;
      in_regwrite = rw;
      in_addr     = a;
      in_data     = d;
   endtask

   initial begin
      reset       = 1'b1;
      drain_stall = 1'b0;
      offer(1'b0, 1'b0, 5'd0, 64'd0);
`ifdef RF_BYPASS_EN
      rd_addr = 5'd0;
`endif
      repeat (2) tick();
      reset = 1'b0;
      repeat (2) tick();

      // Reset then idle
      check("idle_wr_en",    64'(wr_en),    64'd0);
      check("idle_wr_data",  wr_data,       64'd0);
      check("idle_pending",  64'(pending),  64'd0);
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // Single write X5
      offer(1'b1, 1'b1, 5'd5, 64'hDEADBEEF);
      tick();
      offer(1'b0, 1'b0, 5'd0, 64'd0);
      check("single_pend_k",  64'(pending), 64'd1);
      check("single_wren_k",  64'(wr_en),   64'd0);
      tick();
      check("single_wren_k1", 64'(wr_en),   64'h0000_0020);
      check("single_data_k1", wr_data,      64'hDEADBEEF);
      check("single_pend_k1", 64'(pending), 64'd0);
      tick();
      check("single_wren_k2", 64'(wr_en),   64'd0);
      check("single_hold_k2", wr_data,      64'hDEADBEEF);

      // Suppressed writes: X31 and RegWrite=0
      offer(1'b1, 1'b1, 5'd31, 64'h31);
      check("x31_ready", 64'(in_ready), 64'd1);
      tick();
      check("x31_pend", 64'(pending), 64'd0);
      check("x31_wren", 64'(wr_en),   64'd0);
      offer(1'b1, 1'b0, 5'd3, 64'h33);
      tick();
      offer(1'b0, 1'b0, 5'd0, 64'd0);
      check("norw_pend", 64'(pending), 64'd0);
      check("norw_wren", 64'(wr_en),   64'd0);
      tick();
      check("supp_wren_after", 64'(wr_en), 64'd0);

      // Stall fills FIFO, then drains 1/cycle in order
      drain_stall = 1'b1;
      offer(1'b1, 1'b1, 5'd1, 64'd1);
      tick();
      check("stall_pend1", 64'(pending), 64'd1);
      offer(1'b1, 1'b1, 5'd2, 64'd2);
      tick();
      check("stall_pend2",  64'(pending),  64'd2);
      check("stall_full_rdy", 64'(in_ready), 64'd0);
      offer(1'b1, 1'b1, 5'd3, 64'd3);
      tick();
      check("stall_held_pend", 64'(pending), 64'd2);
      check("stall_held_wren", 64'(wr_en),   64'd0);
      drain_stall = 1'b0;
      check("stall_rel_rdy", 64'(in_ready), 64'd0);
      tick();
      check("drain1_wren", 64'(wr_en),   64'h2);
      check("drain1_data", wr_data,      64'd1);
      check("drain1_pend", 64'(pending), 64'd1);
      tick();
      offer(1'b0, 1'b0, 5'd0, 64'd0);
      check("drain2_wren", 64'(wr_en),   64'h4);
      check("drain2_data", wr_data,      64'd2);
      check("drain2_pend", 64'(pending), 64'd1);
      tick();
      check("drain3_wren", 64'(wr_en),   64'h8);
      check("drain3_data", wr_data,      64'd3);
      check("drain3_pend", 64'(pending), 64'd0);
      tick();
      check("drain_done_wren", 64'(wr_en), 64'd0);

      // Reset mid-drain
      drain_stall = 1'b1;
      offer(1'b1, 1'b1, 5'd4, 64'd4);
      tick();
      offer(1'b1, 1'b1, 5'd6, 64'd6);
      tick();
      offer(1'b0, 1'b0, 5'd0, 64'd0);
      check("rst_pre_pend", 64'(pending), 64'd2);
      drain_stall = 1'b0;
      tick();
      check("rst_pre_wren", 64'(wr_en),   64'h10);
      check("rst_pre_pend1", 64'(pending), 64'd1);
      reset = 1'b1;
      #1;
      check("rst_async_wren", 64'(wr_en),    64'd0);
      check("rst_async_pend", 64'(pending),  64'd0);
      check("rst_async_data", wr_data,       64'd0);
      check("rst_async_rdy",  64'(in_ready), 64'd1);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_after_wren", 64'(wr_en), 64'd0);
      end
      check("rst_after_pend", 64'(pending), 64'd0);

`ifdef RF_BYPASS_EN
      // Newest FIFO entry beats the write strobe register
      offer(1'b1, 1'b1, 5'd7, 64'd10);
      tick();
      offer(1'b1, 1'b1, 5'd7, 64'd20);
      tick();
      offer(1'b0, 1'b0, 5'd0, 64'd0);
      drain_stall = 1'b1;
      check("byp_setup_wren", 64'(wr_en), 64'h80);
      rd_addr = 5'd7;
      #1;
      check("byp7_hit",  64'(byp_hit), 64'd1);
      check("byp7_data", byp_data,     64'd20);
      rd_addr = 5'd31;
      #1;
      check("byp31_hit", 64'(byp_hit), 64'd0);
      check("byp31_data", byp_data,    64'd0);
      tick();
      rd_addr = 5'd7;
      #1;
      check("byp7_fifo_only", byp_data, 64'd20);
      drain_stall = 1'b0;
      tick();
      check("byp7_reg_only_hit",  64'(byp_hit), 64'd1);
      check("byp7_reg_only_data", byp_data,     64'd20);
      tick();
      check("byp7_miss", 64'(byp_hit), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
